cordic_scheduler: RTL
=====================

Name: cordic_scheduler

Overview:
Round-robin scheduler that shares one CORDIC rotation core (2.16 signed fixed point, 16 iterations) between N_REQ requesters.
- Accepts one angle request at a time and holds the core's target angle stable for the whole run.
- Pulses the core's init, waits for its done, then returns cos/sin/angle to the winning requester.
- Sits between the angle-producing clients and the CORDIC core instance.

Parameters:
N_REQ, 4, number of requesters (2..8)
WDOG_CYC, 32, WAIT-state cycle limit before the run is aborted with an error

Ports:
clk  in  1  clock; all logic on rising edge
init  in  1  synchronous active-high reset
req_valid  in  N_REQ  per-requester request valid
req_angle  in  18*N_REQ  per-requester target angle, 2.16 signed; requester i occupies bits [18*i+17:18*i]
req_ready  out  N_REQ  one-hot grant; accept = req_valid[i] & req_ready[i]
rsp_valid  out  N_REQ  one-hot, one-cycle result pulse to the owning requester
rsp_cos  out  18  result cosine, 2.16 signed
rsp_sin  out  18  result sine, 2.16 signed
rsp_angle  out  18  achieved angle, 2.16 signed
rsp_err  out  1  qualifies rsp_valid; 1 = watchdog abort, results invalid
busy  out  1  high in every state except IDLE
core_init  out  1  to core init
core_target  out  18  to core target_angle
core_cos  in  18  from core cosine
core_sin  in  18  from core sine
core_angle  in  18  from core angle
core_done  in  1  from core done

Behaviour:
- Reset (init=1):
  - state=IDLE, rr_ptr=0, all rsp_* = 0, req_ready=0, core_target=0, watchdog=0.
  - core_init = init | (state==LAUNCH), so controller reset also resets the core.
  - Reset mid-run discards the run; no rsp_valid is issued.
- States: IDLE -> LAUNCH -> WAIT -> RESP -> IDLE.
- IDLE:
  - req_ready is combinational and asserts only for the winning valid requester.
  - Priority starts at index rr_ptr and wraps upward modulo N_REQ.
  - No valid requester: req_ready=0 and the state holds.
  - On accept: register req_angle slice into core_target and the winner index into owner, then go to LAUNCH.
- LAUNCH: exactly one cycle; core_init=1; clear watchdog; go to WAIT.
- WAIT:
  - core_done is sampled every cycle; core_done=1 captures results and moves to RESP.
  - The core's done is already cleared by the LAUNCH init, so a stale done is never seen.
  - The core asserts done on the 17th WAIT cycle.
  - The watchdog increments each WAIT cycle. If it reaches WDOG_CYC without done, go to RESP with rsp_err=1 and rsp_cos/sin/angle=0.
- RESP: exactly one cycle.
  - rsp_valid[owner]=1; rsp_* are registered and hold their values until the next capture.
  - rr_ptr <= owner+1, wrapping from N_REQ-1 to 0.
  - Go to IDLE.
- Latency: accept in cycle T gives LAUNCH in T+1, WAIT in T+2..T+18 and rsp_valid in T+19. Back-to-back accept is possible at T+20.
- core_target is held constant from accept through RESP, because the core compares against it combinationally every iteration.
- req_valid may drop without acceptance; it is ignored outside IDLE. req_angle is sampled only on the accept cycle.
- Simultaneous requests: the lowest index at or above rr_ptr wins. With all N_REQ requesters held valid, grants rotate 0,1,2,...,N_REQ-1,0.

Optional Feature:
Macro: CORDIC_QUADRANT_FOLD_EN
- Enabled:
  - At accept, compute in 19-bit signed arithmetic with pi = 0x3243F (2.16).
  - If angle > pi/2 (0x1921F), core_target = angle - pi.
  - If angle < -pi/2, core_target = angle + pi.
  - Any fold sets the fold flag.
  - At capture with fold=1: rsp_cos = -core_cos, rsp_sin = -core_sin, rsp_angle = core_angle ± pi, truncated to 18 bits (wraps where out of range).
  - Latency is unchanged.
- Disabled: the angle passes through unchanged and no fold logic is present.

Test Plan:
1. Single request: req_valid[0]=1, req_angle=0x0C910 at cycle T -> req_ready[0]=1 in T; core_init=1 only in T+1; rsp_valid=4'b0001 in T+19; rsp_cos/sin/angle match the bit-exact core model; rsp_err=0.
2. Simultaneous: all four valid, distinct angles -> grant order 0,1,2,3; each rsp_valid one-hot, 20 cycles apart; each result matches its own angle.
3. Round-robin wrap: after owner 3 completes, requesters 0 and 2 valid -> 0 granted (rr_ptr=0); next grant goes to 2.
4. Watchdog: core_done tied 0 -> rsp_valid[owner]=1 with rsp_err=1 in cycle T+2+WDOG_CYC; results 0; next request accepted normally.
5. Reset mid-run: init=1 in T+8 -> core_init=1 that cycle; no rsp_valid; busy=0 and rr_ptr=0 next cycle; a new request then completes in 19 cycles.
6. Fold (macro on): req_angle=0x1C000 (1.75 rad) -> core_target=0x1C000-0x3243F (-1.3916 rad); rsp_cos, rsp_sin = negated core outputs; latency stays T+19. Macro off: core_target=0x1C000.

Source files
------------

// File: rtl/cordic_scheduler.sv
// Round-robin front end sharing one 16-iteration CORDIC rotation core between N_REQ requesters.
// Optional macro CORDIC_QUADRANT_FOLD_EN folds angles beyond +/-pi/2 into the core's convergence range.
module cordic_scheduler #(
    parameter int N_REQ    = 4,
    parameter int WDOG_CYC = 32
) (
    input  logic                  clk,
    input  logic                  init,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [18*N_REQ-1:0]   req_angle,
    output logic [N_REQ-1:0]      req_ready,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [17:0]           rsp_cos,
    output logic [17:0]           rsp_sin,
    output logic [17:0]           rsp_angle,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  core_init,
    output logic [17:0]           core_target,
    input  logic [17:0]           core_cos,
    input  logic [17:0]           core_sin,
    input  logic [17:0]           core_angle,
    input  logic                  core_done
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WD_W  = $clog2(WDOG_CYC + 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W:0]     cand;
    logic               win_found;
    logic [17:0]        sel_angle;
    logic [17:0]        acc_target;
    logic [WD_W-1:0]    wdog;

    // Scan from rr_ptr upward with wrap; descending loop lets the nearest valid index win last.
    // NOTE: every always_comb output gets a default before any conditional assignment, so no latch is inferred.
    always_comb begin
        winner    = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N_REQ))
                cand = cand - (IDX_W+1)'(N_REQ);
            if (req_valid[cand[IDX_W-1:0]]) begin
                winner    = cand[IDX_W-1:0];
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        sel_angle = '0;
        for (int i = 0; i < N_REQ; i++)
            if (winner == IDX_W'(i))
                sel_angle = req_angle[18*i +: 18];
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && !init && win_found)
            req_ready = N_REQ'(1) << winner;
    end

    // The core is reset together with the controller, and re-armed once per run.
    assign core_init = init | (state == LAUNCH);
    assign busy      = (state != IDLE);

`ifdef CORDIC_QUADRANT_FOLD_EN
    localparam logic signed [18:0] PI19    = 19'sh3243F;
    localparam logic signed [18:0] HALF_PI = 19'sh1921F;
    localparam logic [17:0]        PI18    = 18'h3243F;

    logic signed [18:0] acc_ext;
    logic               acc_fold;
    logic               acc_sub;
    logic               fold;
    logic               fold_sub;

    // acc_sub marks a fold that subtracted pi, so pi is added back to the achieved angle.
    always_comb begin
        acc_ext    = {sel_angle[17], sel_angle};
        acc_target = sel_angle;
        acc_fold   = 1'b0;
        acc_sub    = 1'b0;
        if (acc_ext > HALF_PI) begin
            acc_target = 18'(acc_ext - PI19);
            acc_fold   = 1'b1;
            acc_sub    = 1'b1;
        end else if (acc_ext < -HALF_PI) begin
            acc_target = 18'(acc_ext + PI19);
            acc_fold   = 1'b1;
        end
    end
`else
    assign acc_target = sel_angle;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
    always_ff @(posedge clk) begin
        if (init) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            owner       <= '0;
            core_target <= '0;
            wdog        <= '0;
            rsp_valid   <= '0;
            rsp_cos     <= '0;
            rsp_sin     <= '0;
            rsp_angle   <= '0;
            rsp_err     <= 1'b0;
`ifdef CORDIC_QUADRANT_FOLD_EN
            fold        <= 1'b0;
            fold_sub    <= 1'b0;
`endif
        end else begin
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        core_target <= acc_target;
                        owner       <= winner;
`ifdef CORDIC_QUADRANT_FOLD_EN
                        fold        <= acc_fold;
                        fold_sub    <= acc_sub;
`endif
                        state       <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    wdog  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (core_done) begin
`ifdef CORDIC_QUADRANT_FOLD_EN
                        if (fold) begin
                            rsp_cos   <= -core_cos;
                            rsp_sin   <= -core_sin;
                            rsp_angle <= fold_sub ? core_angle + PI18 : core_angle - PI18;
                        end else begin
                            rsp_cos   <= core_cos;
                            rsp_sin   <= core_sin;
                            rsp_angle <= core_angle;
                        end
`else
                        rsp_cos   <= core_cos;
                        rsp_sin   <= core_sin;
                        rsp_angle <= core_angle;
`endif
                        rsp_err   <= 1'b0;
                        rsp_valid <= N_REQ'(1) << owner;
                        state     <= RESP;
                    end else if (wdog == WD_W'(WDOG_CYC - 1)) begin
                        // This is the WDOG_CYC-th WAIT cycle without done: abort the run.
                        rsp_cos   <= '0;
                        rsp_sin   <= '0;
                        rsp_angle <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= N_REQ'(1) << owner;
                        state     <= RESP;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                RESP: begin
                    rr_ptr <= (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
